// File: rtl/ucode_pkg.sv
// ucode_pkg: shared constants and types for the writable control store loader.
//   UC_WORD_W / UC_ADDR_W / UC_DEPTH : microinstruction width, address width, depth
//   UC_BYTES_PER_WORD                : stream bytes consumed per microinstruction
//   UC_NOP                           : word presented to the sequencer while loading
//   state_t                          : loader FSM states
package ucode_pkg;

    localparam int UC_WORD_W         = 37;
    localparam int UC_ADDR_W         = 5;
    localparam int UC_DEPTH          = 32;
    localparam int UC_BYTES_PER_WORD = 5;

    localparam logic [UC_WORD_W-1:0] UC_NOP = '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CSUM
    } state_t;

    // A requested word count of 0 means a full control store.
    function automatic logic [5:0] words_to_load(input logic [5:0] n);
        return (n == 6'd0) ? 6'(UC_DEPTH) : n;
    endfunction

endpackage

// File: rtl/ucode_loader_if.sv
// ucode_loader_if: bundles the loader's control, byte stream and read port.
//   start/num_words : load request (pulse) and word count
//   in_data/in_valid/in_ready : byte stream
//   rd_addr/rd_data : sequencer read port into the control store
//   busy/core_halt/done/err : load status
//   dbg_state       : current loader FSM state
//
// Stream handshake: a byte moves on a rising edge exactly when in_valid and
// in_ready are both high. in_ready depends only on loader state, never on
// in_valid, so a producer may hold in_valid low for any number of cycles.
interface ucode_loader_if;
    import ucode_pkg::*;

    logic                 start;
    logic [5:0]           num_words;
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [UC_ADDR_W-1:0] rd_addr;
    logic [UC_WORD_W-1:0] rd_data;
    logic                 busy;
    logic                 core_halt;
    logic                 done;
    logic                 err;
    state_t               dbg_state;

    modport slave (
        input  start, num_words, in_data, in_valid, rd_addr,
        output in_ready, rd_data, busy, core_halt, done, err, dbg_state
    );

    modport master (
        output start, num_words, in_data, in_valid, rd_addr,
        input  in_ready, rd_data, busy, core_halt, done, err, dbg_state
    );

endinterface

// File: rtl/wcs_ram.sv
// wcs_ram: writable control store, DEPTH x WORD_W.
//   clk, rst  : clock; synchronous reset clears every entry
//   i_we, i_waddr, i_wdata : synchronous write port
//   i_raddr, o_rdata       : asynchronous read port
module wcs_ram
    import ucode_pkg::*;
#(
    parameter int WORD_W = UC_WORD_W,
    parameter int ADDR_W = UC_ADDR_W,
    parameter int DEPTH  = UC_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ucode_loader.sv
// ucode_loader: assembles a byte stream into 37-bit microinstructions, writes
// them into the control store, and checks a trailing XOR checksum byte.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ucode_loader_if.slave (load request, byte stream, read port,
//              busy/core_halt/done/err status, dbg_state)
module ucode_loader
    import ucode_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    ucode_loader_if.slave  bus
);

    state_t               r_state;
    state_t               w_next_state;
    logic [2:0]           r_byte_cnt;
    logic [5:0]           r_word_cnt;
    logic [5:0]           r_num_words;
    logic [7:0]           r_csum;
    logic [31:0]          r_asm;
    logic                 r_done;
    logic                 r_err;

    logic                 w_in_ready;
    logic                 w_xfer;
    logic                 w_we;
    logic                 w_start_ok;
    logic                 w_last_word;
    logic                 w_busy;
    logic [UC_WORD_W-1:0] w_wdata;
    logic [UC_WORD_W-1:0] w_rdata;

    assign w_xfer      = bus.in_valid & w_in_ready;
    assign w_last_word = (r_word_cnt == (r_num_words - 6'd1));
    // Byte 4 completes the word: only its low 5 bits are stored.
    assign w_wdata     = {bus.in_data[4:0], r_asm};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_we         = 1'b0;
        w_start_ok   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_start_ok   = 1'b1;
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && (r_byte_cnt == 3'd4)) begin
                    w_we = 1'b1;
                    if (w_last_word) begin
                        w_next_state = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt  <= '0;
            r_word_cnt  <= '0;
            r_num_words <= '0;
            r_csum      <= '0;
            r_asm       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_ok) begin
                r_num_words <= words_to_load(bus.num_words);
                r_byte_cnt  <= '0;
                r_word_cnt  <= '0;
                r_csum      <= '0;
                r_err       <= 1'b0;
            end
            if ((r_state == S_LOAD) && w_xfer) begin
                r_csum <= r_csum ^ bus.in_data;
                case (r_byte_cnt)
                    3'd0:    r_asm[7:0]   <= bus.in_data;
                    3'd1:    r_asm[15:8]  <= bus.in_data;
                    3'd2:    r_asm[23:16] <= bus.in_data;
                    3'd3:    r_asm[31:24] <= bus.in_data;
                    default: ;
                endcase
                if (r_byte_cnt == 3'd4) begin
                    r_byte_cnt <= '0;
                    r_word_cnt <= r_word_cnt + 6'd1;
                end else begin
                    r_byte_cnt <= r_byte_cnt + 3'd1;
                end
            end
            if ((r_state == S_CSUM) && w_xfer) begin
                r_done <= 1'b1;
                if (bus.in_data != r_csum) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    wcs_ram u_wcs_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (r_word_cnt[UC_ADDR_W-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (bus.rd_addr),
        .o_rdata (w_rdata)
    );

    // busy decodes the state register, so it rises the cycle after start and
    // falls the cycle after the checksum byte.
    assign w_busy        = (r_state != S_IDLE);
    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = w_busy;
    assign bus.core_halt = w_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    // The sequencer sees NOPs for the whole load, never a half-written word.
    assign bus.rd_data   = w_busy ? UC_NOP : w_rdata;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_ucode_loader.sv
module tb_ucode_loader;
    import ucode_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ucode_loader_if bus ();

    ucode_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int nop_viol = 0;

    logic [UC_WORD_W-1:0] model_mem [UC_DEPTH];
    logic                 model_err;
    logic [UC_WORD_W-1:0] exp_q [$];
    logic [7:0]           byte_q [$];

    typedef struct packed {
        logic [39:0]          bytes;    // byte 0 in [39:32] ... byte 4 in [7:0]
        logic [7:0]           csum;
        logic [UC_WORD_W-1:0] exp_word;
        logic                 exp_err;
    } vec_t;

    vec_t vecs [5];

    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (bus.busy && (bus.rd_data !== '0)) nop_viol++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_load(input logic [5:0] n);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.num_words = n;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.num_words = 6'($urandom_range(0, 63));
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gaps;
        bit ok;
        gaps = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        repeat (gaps) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom_range(0, 255));
            bus.rd_addr  = 5'($urandom_range(0, 31));
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.rd_addr  = 5'($urandom_range(0, 31));
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("in_ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_load(input logic [5:0] n, input logic [7:0] csum, input int max_gap);
        start_load(n);
        foreach (byte_q[i]) send_byte(byte_q[i], max_gap);
        send_byte(csum, max_gap);
        repeat (2) @(negedge clk);
        #1;
    endtask

    // Reference: word w is bytes 5w..5w+4 little-endian, top byte cut to 5 bits;
    // checksum is the XOR of every data byte.
    task automatic model_load(input logic [5:0] n, input logic [7:0] csum);
        int nn;
        logic [7:0] x;
        nn = (n == 6'd0) ? UC_DEPTH : int'(n);
        x = 8'h00;
        foreach (byte_q[i]) x ^= byte_q[i];
        for (int w = 0; w < nn; w++) begin
            model_mem[w] = {byte_q[5*w+4][4:0], byte_q[5*w+3], byte_q[5*w+2],
                            byte_q[5*w+1], byte_q[5*w]};
        end
        model_err = (x != csum);
    endtask

    task automatic model_clear();
        for (int a = 0; a < UC_DEPTH; a++) model_mem[a] = '0;
        model_err = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        for (int a = 0; a < UC_DEPTH; a++) exp_q.push_back(model_mem[a]);
        for (int a = 0; a < UC_DEPTH; a++) begin
            @(negedge clk);
            bus.rd_addr = 5'(a);
            #1;
            chk($sformatf("%s_mem%0d", tag, a), 64'(bus.rd_data), 64'(exp_q.pop_front()));
        end
    endtask

    task automatic read_at(input int a, output logic [UC_WORD_W-1:0] d);
        @(negedge clk);
        bus.rd_addr = 5'(a);
        #1;
        d = bus.rd_data;
    endtask

    initial begin
        logic [UC_WORD_W-1:0] rd;
        logic [7:0] cs;
        logic [5:0] n;
        int nn;
        int d0;

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.num_words = '0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.rd_addr   = '0;

        vecs[0] = '{40'h11223344FF, 8'hBB, 37'h1F44332211, 1'b0};
        vecs[1] = '{40'h0000000000, 8'h00, 37'h0000000000, 1'b0};
        vecs[2] = '{40'hFFFFFFFFFF, 8'hFF, 37'h1FFFFFFFFF, 1'b0};
        vecs[3] = '{40'hA55A0FF0E3, 8'hE3, 37'h03F00F5AA5, 1'b0};
        vecs[4] = '{40'h11223344FF, 8'hBA, 37'h1F44332211, 1'b1};

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_core_halt", 64'(bus.core_halt), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_state", 64'(bus.dbg_state), 64'(S_IDLE));
        rst = 1'b0;
        model_clear();
        check_mem("reset");

        // Single-word table
        for (int v = 0; v < 5; v++) begin
            byte_q = {};
            for (int k = 0; k < 5; k++) byte_q.push_back(vecs[v].bytes[39-8*k -: 8]);
            d0 = done_cnt;
            run_load(6'd1, vecs[v].csum, 0);
            model_load(6'd1, vecs[v].csum);
            chk($sformatf("tbl%0d_done", v), 64'(done_cnt - d0), 64'd1);
            chk($sformatf("tbl%0d_busy", v), 64'(bus.busy), 64'd0);
            chk($sformatf("tbl%0d_err", v), 64'(bus.err), 64'(vecs[v].exp_err));
            read_at(0, rd);
            chk($sformatf("tbl%0d_word", v), 64'(rd), 64'(vecs[v].exp_word));
        end

        // Sticky err, cleared by the next start
        repeat (5) @(negedge clk);
        chk("err_sticky", 64'(bus.err), 64'd1);
        start_load(6'd1);
        chk("err_cleared_on_start", 64'(bus.err), 64'd0);
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        byte_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        foreach (byte_q[i]) send_byte(byte_q[i], 0);
        send_byte(8'h01, 0);
        repeat (2) @(negedge clk);
        model_load(6'd1, 8'h01);
        chk("err_clear_load_err", 64'(bus.err), 64'(model_err));

        // Full load with backpressure
        byte_q = {};
        for (int i = 0; i < 32; i++) repeat (5) byte_q.push_back(8'(i));
        nop_viol = 0;
        d0 = done_cnt;
        run_load(6'd0, 8'h00, 3);
        model_load(6'd0, 8'h00);
        chk("full_nop_while_busy", 64'(nop_viol), 64'd0);
        chk("full_done", 64'(done_cnt - d0), 64'd1);
        chk("full_err", 64'(bus.err), 64'd0);
        read_at(5, rd);
        chk("full_entry5", 64'(rd), 64'h0505050505);
        read_at(31, rd);
        chk("full_entry31", 64'(rd), 64'h1F1F1F1F1F);
        check_mem("full");

        // start while busy is ignored
        byte_q = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        d0 = done_cnt;
        start_load(6'd1);
        for (int i = 0; i < 3; i++) send_byte(byte_q[i], 0);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.num_words = 6'd5;
        @(negedge clk);
        bus.start     = 1'b0;
        send_byte(byte_q[3], 0);
        send_byte(byte_q[4], 0);
        send_byte(8'hEE, 0);
        repeat (2) @(negedge clk);
        #1;
        model_load(6'd1, 8'hEE);
        chk("busy_start_busy", 64'(bus.busy), 64'd0);
        chk("busy_start_done", 64'(done_cnt - d0), 64'd1);
        chk("busy_start_err", 64'(bus.err), 64'd0);
        read_at(0, rd);
        chk("busy_start_word", 64'(rd), 64'h0EDDCCBBAA);

        // Reset mid-load
        start_load(6'd2);
        for (int i = 0; i < 7; i++) send_byte(8'(8'h40 + i), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid_busy", 64'(bus.busy), 64'd0);
        chk("rstmid_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rstmid_state", 64'(bus.dbg_state), 64'(S_IDLE));
        model_clear();
        check_mem("rstmid");
        byte_q = {};
        for (int i = 0; i < 10; i++) byte_q.push_back(8'($urandom_range(0, 255)));
        cs = 8'h00;
        foreach (byte_q[i]) cs ^= byte_q[i];
        d0 = done_cnt;
        run_load(6'd2, cs, 1);
        model_load(6'd2, cs);
        chk("rstmid_reload_done", 64'(done_cnt - d0), 64'd1);
        chk("rstmid_reload_err", 64'(bus.err), 64'(model_err));
        check_mem("rstmid_reload");

        // Randomized loads against the reference model
        for (int it = 0; it < 6; it++) begin
            n  = 6'($urandom_range(0, 32));
            nn = (n == 6'd0) ? 32 : int'(n);
            byte_q = {};
            for (int i = 0; i < 5 * nn; i++) byte_q.push_back(8'($urandom_range(0, 255)));
            cs = 8'h00;
            foreach (byte_q[i]) cs ^= byte_q[i];
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
            nop_viol = 0;
            d0 = done_cnt;
            run_load(n, cs, 2);
            model_load(n, cs);
            chk($sformatf("rand%0d_done", it), 64'(done_cnt - d0), 64'd1);
            chk($sformatf("rand%0d_err", it), 64'(bus.err), 64'(model_err));
            chk($sformatf("rand%0d_nop", it), 64'(nop_viol), 64'd0);
            check_mem($sformatf("rand%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ucode_loader.md
Name: ucode_loader

Overview:
- Writer side of the microprogram control store: receives a byte stream, assembles 37-bit microinstructions and writes them into a 32-entry writable control store.
- Exposes a combinational read port that the sequencer's next-address register indexes in place of a fixed ROM.
- Holds the core halted and presents NOP words while a load is in progress.
- Verifies a trailing XOR checksum and flags load errors.

Parameters:
- WORD_W, 37, microinstruction width in bits
- ADDR_W, 5, control-store address width
- DEPTH, 32, number of control-store entries (2**ADDR_W)
- BYTES_PER_WORD, 5, stream bytes per microinstruction

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse; begins a load (honoured only in IDLE)
- num_words  input  6  words to load, sampled on start; 1..32, value 0 means 32
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts the byte this cycle
- rd_addr  input  5  sequencer microaddress
- rd_data  output  37  microinstruction at rd_addr
- busy  output  1  load in progress (LOAD or CSUM)
- core_halt  output  1  equals busy; stalls the sequencer
- done  output  1  one-cycle pulse when the checksum byte is consumed
- err  output  1  sticky checksum-mismatch flag

Behaviour:
- Reset: state=IDLE; all 32 entries cleared to 0; in_ready=0, busy=0, core_halt=0, done=0, err=0; internal counters and checksum cleared. Reset mid-load abandons the load and clears memory.
- Byte transfer occurs only when in_valid&in_ready. No byte is accepted in IDLE.
- IDLE: in_ready=0. On start, latch num_words (0 maps to 32), clear byte_cnt, word_cnt and csum, clear err, then go to LOAD. The first byte can be accepted on the cycle after start.
- LOAD: in_ready=1. Each transfer:
  - csum ^= in_data
  - byte k (k = byte_cnt 0..4) is stored in assembly bits [8k+7:8k]
  - on byte 4, write mem[word_cnt] = {byte4[4:0], byte3, byte2, byte1, byte0} in the same edge; byte4[7:5] are discarded but still included in csum
  - byte_cnt wraps 4 -> 0 and word_cnt increments
  - after the write of word_cnt == N-1, go to CSUM
- CSUM: in_ready=1. On transfer:
  - compare in_data to csum; on mismatch set err=1
  - pulse done=1 on the next cycle
  - go to IDLE
  - memory written during the load is kept even when err=1
- Gaps (in_valid=0) stall counters indefinitely with no timeout.
- start while busy is ignored, and num_words is not re-sampled.
- Read port:
  - rd_data = mem[rd_addr], combinational
  - while busy=1, rd_data forces all zeros (NOP) regardless of address, so read-during-write never exposes a partial word
- busy and core_halt are registered: high from the cycle after start until the cycle after the checksum transfer.
- err holds until the next accepted start or rst.
- Entries beyond N-1 keep their previous contents.

Decomposition:
- Shared package ucode_pkg:
  - UC_WORD_W=37, UC_ADDR_W=5, UC_DEPTH=32, UC_NOP='0
  - state enum {S_IDLE, S_LOAD, S_CSUM}
- One sub-module wcs_ram holds the storage: 32x37, synchronous write, asynchronous read, synchronous clear on rst.

Test Plan:
- Reset: assert rst 2 cycles -> in_ready=0, busy=0, err=0, done=0, rd_data=0 for all 32 addresses.
- Single word: start with num_words=1; bytes 0x11,0x22,0x33,0x44,0xFF; checksum 0xBB -> mem[0]=37'h1F44332211, done pulses once, err=0, busy falls, rd_addr=0 returns 37'h1F44332211.
- Full load with backpressure: num_words=0; 160 data bytes (entry i bytes = i,i,i,i,i) plus correct checksum 0x00, with random in_valid gaps -> all 32 entries correct (entry i bytes i,i,i,i,i: lower 32 bits replicate i, bits [36:32]=i[4:0]), rd_data=0 whenever busy=1, exactly one done.
- Bad checksum: repeat single word with checksum 0xBA -> done pulses, err=1 and stays set, mem[0] still written; next start clears err.
- start during busy: pulse start after byte 2 with num_words=5 -> ignored, load completes as 1 word, byte counts unchanged.
- Reset mid-load: assert rst after 7 bytes of a 2-word load -> IDLE, mem[0]=0, busy=0, in_ready=0; a new load then succeeds normally.
